// File: rtl/div_result_bcd.sv
// Sequential double-dabble converter for a divider's 8-bit quotient/remainder pair.
// Optional divide-by-zero detection is enabled by defining DIV_RESULT_BCD_DBZ_EN.
module div_result_bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  quotient,
    input  logic [7:0]  remainder,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] q_bcd,
    output logic [11:0] r_bcd,
    output logic        dbz
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic [7:0]  q_bin_reg, q_bin_next;
    logic [7:0]  r_bin_reg, r_bin_next;
    logic [11:0] q_acc_reg, q_acc_next;
    logic [11:0] r_acc_reg, r_acc_next;
    logic [11:0] q_bcd_reg, q_bcd_next;
    logic [11:0] r_bcd_reg, r_bcd_next;
    logic        dbz_reg, dbz_next;

    logic [11:0] q_adj, r_adj;
    logic [11:0] q_step, r_step;

    // Per-digit add-3 correction ahead of each shift
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign q_adj[gi*4 +: 4] = (q_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                      q_acc_reg[gi*4 +: 4] + 4'd3 : q_acc_reg[gi*4 +: 4];
            assign r_adj[gi*4 +: 4] = (r_acc_reg[gi*4 +: 4] >= 4'd5) ?
                                      r_acc_reg[gi*4 +: 4] + 4'd3 : r_acc_reg[gi*4 +: 4];
        end
    endgenerate

    assign q_step = {q_adj[10:0], q_bin_reg[7]};
    assign r_step = {r_adj[10:0], r_bin_reg[7]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            q_bin_reg <= 8'd0;
            r_bin_reg <= 8'd0;
            q_acc_reg <= 12'd0;
            r_acc_reg <= 12'd0;
            q_bcd_reg <= 12'd0;
            r_bcd_reg <= 12'd0;
            dbz_reg   <= 1'b0;
        end else if (ena) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            q_bin_reg <= q_bin_next;
            r_bin_reg <= r_bin_next;
            q_acc_reg <= q_acc_next;
            r_acc_reg <= r_acc_next;
            q_bcd_reg <= q_bcd_next;
            r_bcd_reg <= r_bcd_next;
            dbz_reg   <= dbz_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        q_bin_next = q_bin_reg;
        r_bin_next = r_bin_reg;
        q_acc_next = q_acc_reg;
        r_acc_next = r_acc_reg;
        q_bcd_next = q_bcd_reg;
        r_bcd_next = r_bcd_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    q_bin_next = quotient;
                    r_bin_next = remainder;
                    q_acc_next = 12'd0;
                    r_acc_next = 12'd0;
                    cnt_next   = 3'd0;
`ifdef DIV_RESULT_BCD_DBZ_EN
                    dbz_next   = (quotient == 8'hFF) && (remainder == 8'hFF);
`else
                    dbz_next   = 1'b0;
`endif
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                q_acc_next = q_step;
                r_acc_next = r_step;
                q_bin_next = {q_bin_reg[6:0], 1'b0};
                r_bin_next = {r_bin_reg[6:0], 1'b0};
                cnt_next   = cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    state_next = DONE;
`ifdef DIV_RESULT_BCD_DBZ_EN
                    // The divider's zero-divisor code is reported as all-ones digits
                    q_bcd_next = dbz_reg ? 12'hFFF : q_step;
                    r_bcd_next = dbz_reg ? 12'hFFF : r_step;
`else
                    q_bcd_next = q_step;
                    r_bcd_next = r_step;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign q_bcd     = q_bcd_reg;
    assign r_bcd     = r_bcd_reg;
    assign dbz       = dbz_reg;

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed plus randomized bench for div_result_bcd against a decimal-arithmetic reference.
module tb_div_result_bcd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  quotient = 8'd0;
    logic [7:0]  remainder = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] q_bcd;
    logic [11:0] r_bcd;
    logic        dbz;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] prev_q = 12'd0;
    logic [11:0] prev_r = 12'd0;

    always #5 clk = ~clk;

    div_result_bcd dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_bcd     (q_bcd),
        .r_bcd     (r_bcd),
        .dbz       (dbz)
    );

    function automatic logic [11:0] to_bcd(input int v);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        return 12'(h * 256 + t * 16 + o);
    endfunction

    function automatic logic is_dbz(input int q, input int r);
`ifdef DIV_RESULT_BCD_DBZ_EN
        return (q == 255) && (r == 255);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; gap_len disabled clocks inserted after the 2nd shift,
    // stall clocks of out_ready=0 held once the result is presented.
    task automatic do_txn(input int q, input int r, input int gap_len, input int stall);
        int          lat;
        int          waitc;
        logic [11:0] eq, er;
        logic        ed;
        ed = is_dbz(q, r);
        eq = ed ? 12'hFFF : to_bcd(q);
        er = ed ? 12'hFFF : to_bcd(r);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_idle", in_ready, 1);
        quotient  = 8'(q);
        remainder = 8'(r);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        quotient  = 8'($urandom);
        remainder = 8'($urandom);
        in_valid  = 1'($urandom_range(0, 1));
        chk("in_ready_shift", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (gap_len > 0 && lat == 2) ena = 1'b0;
            if (gap_len > 0 && lat == 2 + gap_len) ena = 1'b1;
            if (lat == 4) begin
                chk("q_hold_shift", q_bcd, prev_q);
                chk("r_hold_shift", r_bcd, prev_r);
            end
        end
        in_valid = 1'b0;
        ena      = 1'b1;
        chk("latency", lat, 8 + gap_len);
        chk("q_bcd", q_bcd, eq);
        chk("r_bcd", r_bcd, er);
        chk("dbz", dbz, ed);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_q", q_bcd, eq);
            chk("stall_r", r_bcd, er);
            chk("stall_dbz", dbz, ed);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        prev_q = eq;
        prev_r = er;
        $display("txn q=%0d r=%0d gap=%0d stall=%0d lat=%0d q_bcd=%03h r_bcd=%03h dbz=%0d",
                 q, r, gap_len, stall, lat, q_bcd, r_bcd, dbz);
    endtask

    initial begin
        int ov_seen;
        int rq, rr;
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q_bcd, 0);
        chk("rst_r", r_bcd, 0);
        chk("rst_dbz", dbz, 0);

        // Directed cases
        do_txn(28, 4, 0, 0);
        do_txn(255, 0, 0, 0);
        do_txn(0, 0, 0, 0);
        do_txn(255, 255, 0, 0);
        do_txn(28, 4, 0, 0);
        do_txn(137, 92, 0, 5);
        do_txn(64, 7, 3, 0);

        // Reset after the 4th shift, asserted with ena low
        quotient  = 8'd123;
        remainder = 8'd45;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_q", q_bcd, 0);
        chk("mid_rst_r", r_bcd, 0);
        chk("mid_rst_dbz", dbz, 0);
        prev_q = 12'd0;
        prev_r = 12'd0;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("no_valid_after_rst", ov_seen, 0);
        $display("txn reset-abort q=123 r=45 discarded");
        do_txn(99, 63, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            if (n % 6 == 5) begin
                rq = 255;
                rr = 255;
            end else begin
                rq = int'($urandom_range(0, 255));
                rr = int'($urandom_range(0, 255));
            end
            do_txn(rq, rr, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
